// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the request FSM states, register map and default vector base.
package irq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_PRIO_LO = 2'd2;
  localparam logic [1:0] ADDR_PRIO_HI = 2'd3;

  localparam logic [7:0] VECTOR_BASE_DEF = 8'h0A;

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the highest-priority candidate; ties go to the lowest index.
// Ports: i_cand candidate mask, i_prio 2b/source -> o_valid, o_index, o_level.
module irq_priority_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_cand,
  input  logic [2*N-1:0] i_prio,
  output logic           o_valid,
  output logic [2:0]     o_index,
  output logic [1:0]     o_level
);

  // Strict '>' keeps the earliest index on equal priority.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    o_level = '0;
    for (int i = 0; i < N; i++) begin
      if (i_cand[i] && (i_prio[2*i +: 2] > o_level)) begin
        o_valid = 1'b1;
        o_index = 3'(i);
        o_level = i_prio[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with enable/pending/priority regs.
// Ports: clk, reset(async low), irq_src, reg_* bus, cpu_mask/iack in; cpu_irq/level/vector out.
module irq_controller
  import irq_pkg::*;
#(
  parameter int         NUM_SOURCES = 8,
  parameter logic [7:0] VECTOR_BASE = VECTOR_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic [1:0]             reg_addr,
  input  logic [7:0]             reg_wdata,
  input  logic                   reg_write,
  output logic [7:0]             reg_rdata,
  input  logic [1:0]             cpu_mask,
  output logic                   cpu_irq,
  output logic [1:0]             cpu_irq_level,
  output logic [7:0]             cpu_vector,
  input  logic                   cpu_iack
);

  // Unimplemented sources keep their bits at zero.
  localparam logic [7:0] SRC_MASK =
    8'((16'd1 << NUM_SOURCES) - 16'd1);
  localparam logic [15:0] PRIO_MASK =
    16'((32'd1 << (2 * NUM_SOURCES)) - 32'd1);

  irq_state_e             r_state;
  irq_state_e             w_state_n;
  logic [NUM_SOURCES-1:0] r_src_q;
  logic [7:0]             r_pending;
  logic [7:0]             r_enable;
  logic [15:0]            r_prio;
  logic [2:0]             r_idx;
  logic [1:0]             r_level;
  logic [7:0]             r_vec;
  logic                   r_irq;

  logic [7:0] w_edge;
  logic [7:0] w_clr;
  logic [7:0] w_ack_clr;
  logic [7:0] w_pend_n;
  logic [7:0] w_cand;
  logic       w_win_valid;
  logic [2:0] w_win_index;
  logic [1:0] w_win_level;
  logic [1:0] w_lat_prio;
  logic       w_lat_ok;
  logic       w_latch;
  logic       w_ack;

  assign w_edge = 8'(irq_src & ~r_src_q);
  assign w_clr  = (reg_write && reg_addr == ADDR_PENDING)
                ? reg_wdata : 8'd0;
  assign w_ack_clr = w_ack ? (8'd1 << r_idx) : 8'd0;
  // A fresh edge wins over any clear in the same cycle.
  assign w_pend_n =
    ((r_pending & ~w_clr & ~w_ack_clr) | w_edge) & SRC_MASK;

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < 8; i++) begin
      w_cand[i] = r_pending[i] & r_enable[i]
                & (|r_prio[2*i +: 2]);
    end
  end

  irq_priority_encoder #(.N(8)) u_enc (
    .i_cand  (w_cand),
    .i_prio  (r_prio),
    .o_valid (w_win_valid),
    .o_index (w_win_index),
    .o_level (w_win_level)
  );

  // Latched source is still worth presenting at the current mask.
  assign w_lat_prio = r_prio[{r_idx, 1'b0} +: 2];
  assign w_lat_ok   = r_pending[r_idx] && r_enable[r_idx]
                    && (w_lat_prio > cpu_mask);

  always_comb begin
    w_state_n = r_state;
    w_latch   = 1'b0;
    w_ack     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_win_valid && (w_win_level > cpu_mask)) begin
          w_latch   = 1'b1;
          w_state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (cpu_iack) begin
          w_ack     = 1'b1;
          w_state_n = S_ACK;
        end else if (!w_lat_ok) begin
          w_state_n = S_IDLE;
        end else if (w_win_valid
                     && (w_win_index != r_idx)
                     && (w_win_level > r_level)
                     && (w_win_level > cpu_mask)) begin
          w_latch = 1'b1;
        end
      end
      S_ACK:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_src_q   <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_prio    <= '0;
      r_idx     <= '0;
      r_level   <= '0;
      r_vec     <= VECTOR_BASE;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_src_q   <= irq_src;
      r_pending <= w_pend_n;
      if (reg_write && reg_addr == ADDR_ENABLE)
        r_enable <= reg_wdata & SRC_MASK;
      if (reg_write && reg_addr == ADDR_PRIO_LO)
        r_prio[7:0] <= reg_wdata & PRIO_MASK[7:0];
      if (reg_write && reg_addr == ADDR_PRIO_HI)
        r_prio[15:8] <= reg_wdata & PRIO_MASK[15:8];
      if (w_latch) begin
        r_idx   <= w_win_index;
        r_level <= w_win_level;
        r_vec   <= 8'(VECTOR_BASE
                   + {4'd0, w_win_index, 1'b0});
      end
      r_irq <= (w_state_n == S_REQ);
    end
  end

  always_comb begin
    reg_rdata = 8'd0;
    unique case (reg_addr)
      ADDR_ENABLE:  reg_rdata = r_enable;
      ADDR_PENDING: reg_rdata = r_pending;
      ADDR_PRIO_LO: reg_rdata = r_prio[7:0];
      ADDR_PRIO_HI: reg_rdata = r_prio[15:8];
      default:      reg_rdata = 8'd0;
    endcase
  end

  assign cpu_irq       = r_irq;
  assign cpu_irq_level = r_level;
  assign cpu_vector    = r_vec;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic
// checked against an array-based reference model of the controller.
module tb_irq_controller;

  localparam logic [7:0] VB = 8'h0A;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic [7:0] reg_rdata;
  logic [1:0] cpu_mask;
  logic       cpu_irq;
  logic [1:0] cpu_irq_level;
  logic [7:0] cpu_vector;
  logic       cpu_iack;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  irq_controller #(
    .NUM_SOURCES (8),
    .VECTOR_BASE (VB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_write     (reg_write),
    .reg_rdata     (reg_rdata),
    .cpu_mask      (cpu_mask),
    .cpu_irq       (cpu_irq),
    .cpu_irq_level (cpu_irq_level),
    .cpu_vector    (cpu_vector),
    .cpu_iack      (cpu_iack)
  );

  // Reference model: plain arrays, one entry per source.
  int         m_en [8];
  int         m_pend [8];
  int         m_pr [8];
  int         m_srcq [8];
  bit         m_busy;
  bit         m_ack;
  int         m_idx;
  int         m_lvl;
  logic [7:0] m_vec;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_pr[i] = 0; m_srcq[i] = 0;
    end
    m_busy = 0; m_ack = 0; m_idx = 0; m_lvl = 0; m_vec = VB;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      case (a)
        2'd0: v += m_en[i] << i;
        2'd1: v += m_pend[i] << i;
        2'd2: if (i < 4) v += m_pr[i] << (2 * i);
        default: if (i >= 4) v += m_pr[i] << (2 * (i - 4));
      endcase
    end
    return 8'(v);
  endfunction

  // Applies one clock edge of behaviour using pre-edge inputs/state.
  task automatic model_edge();
    int w, wl, clr_ack;
    bit ok, edge_i, clr_i;
    w = -1; wl = 0; clr_ack = -1;
    for (int i = 0; i < 8; i++)
      if (m_pend[i] != 0 && m_en[i] != 0 && m_pr[i] > wl) begin
        w = i; wl = m_pr[i];
      end
    if (m_ack) begin
      m_ack = 0;
    end else if (m_busy) begin
      ok = m_pend[m_idx] != 0 && m_en[m_idx] != 0
           && m_pr[m_idx] > int'(cpu_mask);
      if (cpu_iack) begin
        m_busy = 0; m_ack = 1; clr_ack = m_idx;
      end else if (!ok) begin
        m_busy = 0;
      end else if (w >= 0 && w != m_idx && wl > m_lvl
                   && wl > int'(cpu_mask)) begin
        m_idx = w; m_lvl = wl; m_vec = 8'(int'(VB) + 2 * w);
      end
    end else if (w >= 0 && wl > int'(cpu_mask)) begin
      m_busy = 1;
      m_idx = w; m_lvl = wl; m_vec = 8'(int'(VB) + 2 * w);
    end
    for (int i = 0; i < 8; i++) begin
      edge_i = irq_src[i] && m_srcq[i] == 0;
      clr_i  = (reg_write && reg_addr == 2'd1 && reg_wdata[i])
               || i == clr_ack;
      if (edge_i) m_pend[i] = 1;
      else if (clr_i) m_pend[i] = 0;
      m_srcq[i] = int'(irq_src[i]);
    end
    if (reg_write) begin
      for (int i = 0; i < 8; i++) begin
        if (reg_addr == 2'd0) m_en[i] = int'(reg_wdata[i]);
        if (reg_addr == 2'd2 && i < 4)
          m_pr[i] = int'((reg_wdata >> (2 * i)) & 8'd3);
        if (reg_addr == 2'd3 && i >= 4)
          m_pr[i] = int'((reg_wdata >> (2 * (i - 4))) & 8'd3);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("irq", 32'(cpu_irq), 32'(m_busy));
    chk("level", 32'(cpu_irq_level), 32'(m_lvl));
    chk("vector", 32'(cpu_vector), 32'(m_vec));
    chk("rdata", 32'(reg_rdata), 32'(model_read(reg_addr)));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0; reg_addr = 2'd1;
  endtask

  task automatic ack();
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; reg_addr = 2'd1; reg_wdata = '0;
    reg_write = 1'b0; cpu_mask = 2'd0; cpu_iack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", 32'(cpu_irq), 0);
    chk("rst_level", 32'(cpu_irq_level), 0);
    chk("rst_vector", 32'(cpu_vector), 32'h0A);
    @(negedge clk);
    reset = 1'b1;

    // Single source, latency and acknowledge.
    wr(2'd0, 8'h01);
    wr(2'd2, 8'h02);
    irq_src = 8'h01;
    tick();
    chk("s1_pending", 32'(reg_rdata), 1);
    chk("s1_irq_e0", 32'(cpu_irq), 0);
    irq_src = 8'h00;
    tick();
    chk("s1_irq", 32'(cpu_irq), 1);
    chk("s1_level", 32'(cpu_irq_level), 2);
    chk("s1_vector", 32'(cpu_vector), 32'h0A);
    ack();
    chk("s1_ack_irq", 32'(cpu_irq), 0);
    chk("s1_ack_pend", 32'(reg_rdata), 0);
    tick();
    tick();
    chk("s1_idle", 32'(cpu_irq), 0);

    // Tie between src1 and src3 at priority 3.
    wr(2'd0, 8'h0A);
    wr(2'd2, 8'hCC);
    irq_src = 8'h0A;
    tick();
    irq_src = 8'h00;
    tick();
    chk("tie_first", 32'(cpu_vector), 32'h0C);
    ack();
    tick();
    tick();
    chk("tie_second", 32'(cpu_vector), 32'h10);
    chk("tie_irq", 32'(cpu_irq), 1);
    ack();
    tick();

    // Preemption of src2 (prio 1) by src5 (prio 3).
    wr(2'd0, 8'h24);
    wr(2'd2, 8'h10);
    wr(2'd3, 8'h0C);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    tick();
    chk("pre_low", 32'(cpu_vector), 32'h0E);
    irq_src = 8'h20;
    tick();
    chk("pre_hold", 32'(cpu_irq), 1);
    irq_src = 8'h00;
    tick();
    chk("pre_irq", 32'(cpu_irq), 1);
    chk("pre_level", 32'(cpu_irq_level), 3);
    chk("pre_vector", 32'(cpu_vector), 32'h14);
    ack();
    tick();
    tick();
    chk("pre_back", 32'(cpu_vector), 32'h0E);
    ack();
    tick();

    // Masking, then withdraw by clearing pending.
    wr(2'd0, 8'h01);
    wr(2'd2, 8'h02);
    wr(2'd3, 8'h00);
    cpu_mask = 2'd2;
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    chk("mask_block", 32'(cpu_irq), 0);
    cpu_mask = 2'd1;
    tick();
    chk("mask_open", 32'(cpu_irq), 1);
    wr(2'd1, 8'h01);
    tick();
    chk("withdraw", 32'(cpu_irq), 0);
    tick();

    // Set/clear collision on pending.
    cpu_mask = 2'd0;
    irq_src = 8'h01;
    wr(2'd1, 8'h01);
    chk("collide", 32'(reg_rdata), 1);
    irq_src = 8'h00;
    tick();
    chk("collide_irq", 32'(cpu_irq), 1);

    // Asynchronous reset while presenting.
    #2;
    reset = 1'b0;
    irq_src = 8'h01;
    model_reset();
    #1;
    chk("rr_irq", 32'(cpu_irq), 0);
    chk("rr_vector", 32'(cpu_vector), 32'h0A);
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      chk("rr_reg", 32'(reg_rdata), 0);
    end
    reg_addr = 2'd1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rr_src_edge", 32'(reg_rdata), 1);
    irq_src = 8'h00;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      irq_src  = 8'($urandom) & 8'($urandom);
      cpu_mask = 2'($urandom_range(0, 2));
      cpu_iack = ($urandom_range(0, 5) == 0);
      reg_addr = 2'($urandom);
      reg_wdata = 8'($urandom);
      reg_write = ($urandom_range(0, 7) == 0);
      tick();
    end
    reg_write = 1'b0;
    cpu_iack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 8, meaning the number of interrupt sources; legal range 1..8.
REQ-002 SHALL have parameter VECTOR_BASE, default 8'h0A, meaning the vector-table byte address of source 0.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port irq_src  input  NUM_SOURCES  meaning raw source lines, synchronous to clk, rising-edge triggered.
REQ-006 SHALL have port reg_addr  input  2  meaning register select: 0 enable, 1 pending, 2 priority sources 0-3, 3 priority sources 4-7.
REQ-007 SHALL have port reg_wdata  input  8  meaning register write data.
REQ-008 SHALL have port reg_write  input  1  meaning a one-cycle write strobe.
REQ-009 SHALL have port reg_rdata  output  8  meaning combinational read of the selected register; unimplemented bits read 0.
REQ-010 SHALL have port cpu_mask  input  2  meaning the CPU's current interrupt level.
REQ-011 SHALL have port cpu_irq  output  1  meaning an interrupt request to the CPU.
REQ-012 SHALL have port cpu_irq_level  output  2  meaning the priority of the presented request.
REQ-013 SHALL have port cpu_vector  output  8  meaning the vector address of the presented request.
REQ-014 SHALL have port cpu_iack  input  1  meaning a one-cycle acknowledge pulse from the CPU.

Function
REQ-015 SHALL register irq_src into src_q every cycle, and SHALL set pending[i] on the edge where irq_src[i]=1 and src_q[i]=0.
REQ-016 SHALL clear pending bits by writing 1 to address 1; a same-cycle edge set SHALL win over the clear.
REQ-017 SHALL treat a 2-bit priority per source as field i%4 of register 2 (sources 0-3) or 3 (sources 4-7), with 0 meaning disabled.
REQ-018 SHALL define a candidate as pending & enable & priority!=0; the winner SHALL be the highest priority, with ties going to the lowest index.
REQ-019 SHALL implement states IDLE, REQ and ACK.
REQ-020 SHALL, in IDLE, when a winner exists with priority > cpu_mask: latch its index, level and vector, and enter REQ.
REQ-021 SHALL, in REQ, drive cpu_irq=1 and drive cpu_irq_level and cpu_vector from the latched values.
REQ-022 SHALL, in REQ, re-latch on the next edge if a different winner with strictly higher priority appears, with no ACK in between.
REQ-023 SHALL, in REQ, return to IDLE (cpu_irq=0 next cycle) if the latched source loses pending, enable or priority, or if its level <= cpu_mask.
REQ-024 SHALL, in REQ with cpu_iack=1, clear pending of the latched index and enter ACK; the iack SHALL take precedence over re-latch and withdraw in the same cycle.
REQ-025 SHALL, in ACK, drive cpu_irq=0 for exactly one cycle and then return to IDLE; cpu_iack outside REQ SHALL be ignored.
REQ-026 SHALL compute cpu_vector = (VECTOR_BASE + 2*index) mod 256.
REQ-027 SHALL meet this latency: with an irq_src rise before edge E0, pending=1 after E0 and cpu_irq=1 after E1.
REQ-028 SHALL produce cpu_irq, cpu_irq_level and cpu_vector as registered outputs only.

Reset
REQ-029 SHALL, on reset=0, asynchronously set: state IDLE, src_q 0, pending 0, enable 0, priority 0, cpu_irq 0, cpu_irq_level 0, cpu_vector VECTOR_BASE.
REQ-030 SHALL drop any in-flight request immediately on reset mid-REQ, with no ACK cycle.
REQ-031 SHALL sample src_q as 0 on the first cycle after reset release, so a source already high produces an edge.

Structure
REQ-032 SHALL place the state enum, the register address constants and the VECTOR_BASE default in a shared package irq_pkg.
REQ-033 SHALL implement winner selection in a combinational sub-module irq_priority_encoder (inputs candidate mask and priorities; outputs valid, index, level).

Verification
REQ-034 SHALL cover single source: enable=01, prio0=2, mask=0, pulse src0 -> cpu_irq after 2 edges, level 2, vector 0x0A; iack -> pending 0, one ACK cycle, then idle.
REQ-035 SHALL cover ties: src1 and src3 both at prio 3, simultaneous edges -> vector 0x0C first; after its iack, vector 0x10.
REQ-036 SHALL cover preemption: src2 prio1 in REQ, then src5 prio3 edge -> re-latch to level 3, vector 0x14, no ACK cycle in between.
REQ-037 SHALL cover masking and withdraw: prio 2 with mask=2 -> no cpu_irq; then in REQ, write 1 to pending bit -> cpu_irq=0 next cycle, state IDLE.
REQ-038 SHALL cover the set/clear collision: a write-1 clear on the same edge as a new src edge -> pending stays 1.
REQ-039 SHALL cover reset in REQ: assert reset -> cpu_irq 0 asynchronously, all registers read 0, vector 0x0A.
